// File: rtl/apb_pkg.sv
// Shared types and limits for the APB memory slave.
package apb_pkg;

    // Bus-side FSM state; encodings are fixed so checkers can decode dbg_state.
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SETUP  = 2'b01,
        ACCESS = 2'b10
    } apb_state_e;

    // Largest number of access-phase wait states the counter can hold.
    localparam int WAIT_CYCLES_MAX = 15;

endpackage

// File: rtl/apb_mem_slave_if.sv
// APB bus bundle between a master and the memory slave.
//
// Handshake: the master opens a transfer with P_selx=1, P_enable=0 (setup),
// then holds P_selx=1, P_enable=1 (access) until it sees P_ready=1 on a
// cycle; the transfer completes on the rising edge that ends that cycle.
// P_slverr and P_rdata are only meaningful while P_ready=1.
interface apb_mem_slave_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) ();

    logic [ADDR_WIDTH-1:0]   P_addr;
    logic                    P_selx;
    logic                    P_enable;
    logic                    P_write;
    logic [DATA_WIDTH-1:0]   P_wdata;
    logic [DATA_WIDTH/8-1:0] P_strb;
    logic                    P_ready;
    logic                    P_slverr;
    logic [DATA_WIDTH-1:0]   P_rdata;

    modport master (
        output P_addr, P_selx, P_enable, P_write, P_wdata, P_strb,
        input  P_ready, P_slverr, P_rdata
    );

    modport slave (
        input  P_addr, P_selx, P_enable, P_write, P_wdata, P_strb,
        output P_ready, P_slverr, P_rdata
    );

endinterface

// File: rtl/apb_mem_array.sv
// DEPTH x DATA_WIDTH word store with a byte-strobed write port and an
// asynchronous read port; every word clears on reset.
module apb_mem_array #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 32,
    localparam int BYTES     = DATA_WIDTH / 8,
    localparam int IDX_W     = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [IDX_W-1:0]      widx,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [BYTES-1:0]      wstrb,
    input  logic [IDX_W-1:0]      ridx,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];

    // Merge enabled byte lanes into the addressed word.
    always_comb begin
        mem_d = mem_q;
        if (we) begin
            for (int b = 0; b < BYTES; b++) begin
                if (wstrb[b]) begin
                    mem_d[widx][b*8 +: 8] = wdata[b*8 +: 8];
                end
            end
        end
    end

    // Storage register with asynchronous clear of every word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rdata = mem_q[ridx];

endmodule

// File: rtl/apb_mem_slave.sv
// APB memory slave: IDLE/SETUP/ACCESS FSM, request capture, programmable
// wait states, address checking and a saturating error counter.
module apb_mem_slave
    import apb_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int DEPTH       = 32,
    parameter int WAIT_CYCLES = 0
) (
    input  logic            P_clk,
    input  logic            P_rst_n,
    apb_mem_slave_if.slave  bus,
    output logic [7:0]      err_cnt,
    output apb_state_e      dbg_state
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int OFF_W = $clog2(BYTES);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(WAIT_CYCLES_MAX + 1);
    localparam logic [ADDR_WIDTH:0]   ADDR_LIMIT = (ADDR_WIDTH+1)'(DEPTH * BYTES);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(BYTES - 1);
    localparam logic [CNT_W-1:0]      WAIT_LOAD  = CNT_W'(WAIT_CYCLES);

    apb_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  write_q, write_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [BYTES-1:0]      strb_q, strb_d;
    logic [CNT_W-1:0]      wait_q, wait_d;
    logic [7:0]            err_cnt_q, err_cnt_d;

    logic                  bus_access;
    logic                  ready;
    logic                  addr_err;
    logic                  mem_we;
    logic [IDX_W-1:0]      word_idx;
    logic [DATA_WIDTH-1:0] mem_rdata;

    assign bus_access = bus.P_selx && bus.P_enable;
    assign addr_err   = ({1'b0, addr_q} >= ADDR_LIMIT) || ((addr_q & ALIGN_MASK) != '0);
    assign word_idx   = addr_q[IDX_W+OFF_W-1:OFF_W];

    // State and captured-request registers.
    always_ff @(posedge P_clk or negedge P_rst_n) begin
        if (!P_rst_n) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            write_q   <= 1'b0;
            wdata_q   <= '0;
            strb_q    <= '0;
            wait_q    <= '0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            write_q   <= write_d;
            wdata_q   <= wdata_d;
            strb_q    <= strb_d;
            wait_q    <= wait_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    // Next state: an ACCESS with the counter at zero always completes; an
    // ACCESS that loses select/enable before that is abandoned.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.P_selx && !bus.P_enable) state_d = SETUP;
            SETUP:   state_d = bus_access ? ACCESS : IDLE;
            ACCESS:  if (wait_q == '0 || !bus_access) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request capture on SETUP entry, wait countdown and error counting.
    always_comb begin
        addr_d    = addr_q;
        write_d   = write_q;
        wdata_d   = wdata_q;
        strb_d    = strb_q;
        wait_d    = wait_q;
        err_cnt_d = err_cnt_q;
        if (state_q == IDLE && state_d == SETUP) begin
            addr_d  = bus.P_addr;
            write_d = bus.P_write;
            wdata_d = bus.P_wdata;
            strb_d  = bus.P_strb;
            wait_d  = WAIT_LOAD;
        end else if (state_q == ACCESS && wait_q != '0) begin
            wait_d = wait_q - 1'b1;
        end
        if (ready && addr_err && err_cnt_q != 8'hFF) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    // Bus responses; read data is forced to zero outside a good read completion.
    always_comb begin
        ready        = (state_q == ACCESS) && (wait_q == '0);
        mem_we       = ready && write_q && !addr_err;
        bus.P_ready  = ready;
        bus.P_slverr = ready && addr_err;
        bus.P_rdata  = (ready && !write_q && !addr_err) ? mem_rdata : '0;
    end

    apb_mem_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_mem (
        .clk   (P_clk),
        .rst_n (P_rst_n),
        .we    (mem_we),
        .widx  (word_idx),
        .wdata (wdata_q),
        .wstrb (strb_q),
        .ridx  (word_idx),
        .rdata (mem_rdata)
    );

    assign err_cnt   = err_cnt_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_apb_mem_slave.sv
// Directed bench for apb_mem_slave: three instances with WAIT_CYCLES 0, 3
// and 2 share one driven bus; P_selx is routed only to the chosen instance.
module tb_apb_mem_slave;
    import apb_pkg::*;

    // Clock and reset.
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Shared bus drive and target selection.
    logic [1:0]  sel_dut = 2'd0;
    logic [31:0] addr = '0;
    logic        selx = 1'b0;
    logic        enable = 1'b0;
    logic        write = 1'b0;
    logic [31:0] wdata = '0;
    logic [3:0]  strb = '0;

    logic        rdy_a    [3];
    logic        slverr_a [3];
    logic [31:0] rdata_a  [3];
    logic [7:0]  errc_a   [3];
    apb_state_e  state_a  [3];

    apb_mem_slave_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus [3] ();

    for (genvar g = 0; g < 3; g++) begin : g_dut
        assign bus[g].P_addr   = addr;
        assign bus[g].P_selx   = selx && (sel_dut == 2'(g));
        assign bus[g].P_enable = enable;
        assign bus[g].P_write  = write;
        assign bus[g].P_wdata  = wdata;
        assign bus[g].P_strb   = strb;
        assign rdy_a[g]        = bus[g].P_ready;
        assign slverr_a[g]     = bus[g].P_slverr;
        assign rdata_a[g]      = bus[g].P_rdata;

        apb_mem_slave #(
            .DATA_WIDTH  (32),
            .ADDR_WIDTH  (32),
            .DEPTH       (32),
            .WAIT_CYCLES (g == 0 ? 0 : (g == 1 ? 3 : 2))
        ) u_dut (
            .P_clk     (clk),
            .P_rst_n   (rst_n),
            .bus       (bus[g]),
            .err_cnt   (errc_a[g]),
            .dbg_state (state_a[g])
        );
    end

    logic        rdy, slverr_o;
    logic [31:0] rdata_o;
    logic [7:0]  errc;
    apb_state_e  cur_state;
    assign rdy       = rdy_a[sel_dut];
    assign slverr_o  = slverr_a[sel_dut];
    assign rdata_o   = rdata_a[sel_dut];
    assign errc      = errc_a[sel_dut];
    assign cur_state = state_a[sel_dut];

    // Scoreboard counters and the single checker.
    int tests_run = 0;
    int tests_failed = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One complete transfer; counts cycles spent out of IDLE and ACCESS
    // cycles without P_ready, bounded by a cycle budget.
    task automatic apb_xfer(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                            input logic [3:0] sb, output logic [31:0] rd, output logic err,
                            output int tot, output int waits, output logic done);
        rd = '0; err = 1'b0; tot = 0; waits = 0; done = 1'b0;
        @(negedge clk);
        selx = 1'b1; enable = 1'b0; write = wr; addr = a; wdata = wd; strb = sb;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (cur_state != IDLE) tot++;
            if (cur_state == ACCESS && !rdy) waits++;
            if (cur_state == SETUP) enable = 1'b1;
            if (rdy) begin
                rd = rdata_o; err = slverr_o; done = 1'b1;
            end
        end
    endtask

    task automatic bus_idle();
        @(negedge clk);
        selx = 1'b0; enable = 1'b0;
    endtask

    logic [31:0] rd;
    logic        er, dn;
    int          tot, wt;

    initial begin
        // Reset values.
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(rdy), 32'd0);
        check("rst_slverr", 32'(slverr_o), 32'd0);
        check("rst_rdata", rdata_o, 32'd0);
        check("rst_errcnt", 32'(errc), 32'd0);
        check("rst_state", 32'(cur_state), 32'(IDLE));
        rst_n = 1'b1;

        // Zero-wait full write then read.
        sel_dut = 2'd0;
        apb_xfer(1'b1, 32'h08, 32'hDEADBEEF, 4'hF, rd, er, tot, wt, dn);
        check("w08_done", 32'(dn), 32'd1);
        check("w08_cycles", 32'(tot), 32'd2);
        check("w08_slverr", 32'(er), 32'd0);
        apb_xfer(1'b0, 32'h08, 32'h0, 4'h0, rd, er, tot, wt, dn);
        check("r08_cycles", 32'(tot), 32'd2);
        check("r08_slverr", 32'(er), 32'd0);
        check("r08_data", rd, 32'hDEADBEEF);

        // Single-lane strobed write.
        apb_xfer(1'b1, 32'h08, 32'h000000AA, 4'h1, rd, er, tot, wt, dn);
        apb_xfer(1'b0, 32'h08, 32'h0, 4'h0, rd, er, tot, wt, dn);
        check("r08_strb", rd, 32'hDEADBEAA);
        bus_idle();
        check("idle_rdata", rdata_o, 32'd0);

        // Error transfers: out of range and misaligned.
        apb_xfer(1'b1, 32'h80, 32'h12345678, 4'hF, rd, er, tot, wt, dn);
        check("w80_slverr", 32'(er), 32'd1);
        apb_xfer(1'b1, 32'h06, 32'h12345678, 4'hF, rd, er, tot, wt, dn);
        check("w06_slverr", 32'(er), 32'd1);
        bus_idle();
        check("errcnt_2", 32'(errc), 32'd2);
        apb_xfer(1'b0, 32'h00, 32'h0, 4'h0, rd, er, tot, wt, dn);
        check("r00_untouched", rd, 32'd0);
        apb_xfer(1'b0, 32'h04, 32'h0, 4'h0, rd, er, tot, wt, dn);
        check("r04_untouched", rd, 32'd0);
        apb_xfer(1'b0, 32'h80, 32'h0, 4'h0, rd, er, tot, wt, dn);
        check("r80_slverr", 32'(er), 32'd1);
        check("r80_rdata", rd, 32'd0);
        apb_xfer(1'b0, 32'h08, 32'h0, 4'h0, rd, er, tot, wt, dn);
        check("r08_after_err", rd, 32'hDEADBEAA);
        bus_idle();
        check("errcnt_3", 32'(errc), 32'd3);

        // Three wait states on a read.
        sel_dut = 2'd1;
        apb_xfer(1'b0, 32'h04, 32'h0, 4'h0, rd, er, tot, wt, dn);
        check("w3_done", 32'(dn), 32'd1);
        check("w3_waits", 32'(wt), 32'd3);
        check("w3_cycles", 32'(tot), 32'd5);
        check("w3_rdata", rd, 32'd0);
        bus_idle();

        // Abort in the first access cycle with two wait states.
        sel_dut = 2'd2;
        apb_xfer(1'b1, 32'h10, 32'h11111111, 4'hF, rd, er, tot, wt, dn);
        check("w2_slverr", 32'(er), 32'd0);
        check("w2_waits", 32'(wt), 32'd2);
        @(negedge clk);
        selx = 1'b1; enable = 1'b0; write = 1'b1; addr = 32'h10; wdata = 32'h22222222; strb = 4'hF;
        @(negedge clk);
        enable = 1'b1;
        @(negedge clk);
        check("abort_in_access", 32'(cur_state), 32'(ACCESS));
        check("abort_ready", 32'(rdy), 32'd0);
        selx = 1'b0; enable = 1'b0;
        @(negedge clk);
        check("abort_state", 32'(cur_state), 32'(IDLE));
        apb_xfer(1'b0, 32'h10, 32'h0, 4'h0, rd, er, tot, wt, dn);
        check("abort_mem", rd, 32'h11111111);
        bus_idle();
        check("abort_errcnt", 32'(errc), 32'd0);

        // Error counter saturation.
        sel_dut = 2'd0;
        for (int i = 0; i < 252; i++) begin
            apb_xfer(1'b1, 32'h101, 32'h0, 4'hF, rd, er, tot, wt, dn);
        end
        bus_idle();
        check("errcnt_255", 32'(errc), 32'd255);
        apb_xfer(1'b1, 32'h101, 32'h0, 4'hF, rd, er, tot, wt, dn);
        bus_idle();
        check("errcnt_sat", 32'(errc), 32'd255);

        // Reset during the completing cycle of a write.
        @(negedge clk);
        selx = 1'b1; enable = 1'b0; write = 1'b1; addr = 32'h08; wdata = 32'hCAFEF00D; strb = 4'hF;
        @(negedge clk);
        enable = 1'b1;
        @(negedge clk);
        check("mid_ready", 32'(rdy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_ready", 32'(rdy), 32'd0);
        check("mid_rst_state", 32'(cur_state), 32'(IDLE));
        check("mid_rst_errcnt", 32'(errc), 32'd0);
        @(negedge clk);
        @(negedge clk);
        selx = 1'b0; enable = 1'b0;
        rst_n = 1'b1;
        apb_xfer(1'b0, 32'h08, 32'h0, 4'h0, rd, er, tot, wt, dn);
        check("mid_rst_mem", rd, 32'd0);
        bus_idle();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Global time bound.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
